// File: rtl/h264_bitstream_reader.sv
// MSB-first bit reader serving u(n), ue(v) and se(v) parse commands from a (VE,VL) word stream.
// Optional: define H264_BITREADER_BITCNT_EN to add the BITPOS consumed-bit counter output.
module h264_bitstream_reader #(
    parameter int BUFW = 64,
    parameter int VALW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [19:0]     VE,
    input  logic [4:0]      VL,
    input  logic            VALID,
    output logic            READY,
    input  logic            CMD_VALID,
    input  logic [1:0]      CMD_OP,
    input  logic [4:0]      CMD_N,
    output logic            CMD_READY,
    output logic            RES_VALID,
    output logic [VALW-1:0] RES_VALUE,
    output logic            RES_ERR
`ifdef H264_BITREADER_BITCNT_EN
    ,
    output logic [31:0]     BITPOS
`endif
);

    localparam int FW = $clog2(BUFW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [BUFW-1:0]   bitbuf;
    logic [FW-1:0]     fill;
    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [4:0]        n_q;

    logic              found;
    int unsigned       lz;
    logic [2*VALW-1:0] top;
    logic [2*VALW-1:0] code;
    logic [VALW-1:0]   k;
    logic              eval_done;
    logic              eval_err;
    logic [VALW-1:0]   eval_val;
    int unsigned       eval_cons;
    int unsigned       consume;

    logic [4:0]        vl_eff;
    logic              accept;
    logic [19:0]       wl;
    logic [FW-1:0]     fill_c;
    logic [BUFW-1:0]   ins;
    logic [BUFW-1:0]   buf_next;
    logic [FW-1:0]     fill_next;

    assign READY     = !RST && (32'(fill) <= BUFW - 20);
    assign CMD_READY = !RST && (state == S_IDLE);
    assign RES_VALID = !RST && (state == S_DONE);

    // Leading-zero count restricted to the valid part of the top VALW bits
    always_comb begin
        lz    = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < VALW; i++) begin
            if (!found && i < 32'(fill)) begin
                if (bitbuf[BUFW-1-i]) found = 1'b1;
                else                  lz = lz + 1;
            end
        end
    end

    always_comb begin
        top       = bitbuf[BUFW-1 -: 2*VALW];
        code      = '0;
        k         = '0;
        eval_done = 1'b0;
        eval_err  = 1'b0;
        eval_val  = '0;
        eval_cons = 0;
        case (op_q)
            2'd0: begin
                if (32'(n_q) > VALW) begin
                    eval_done = 1'b1;
                    eval_err  = 1'b1;
                end else if (n_q == 5'd0) begin
                    eval_done = 1'b1;
                end else if (32'(fill) >= 32'(n_q)) begin
                    eval_done = 1'b1;
                    eval_val  = VALW'(top >> (2*VALW - 32'(n_q)));
                    eval_cons = 32'(n_q);
                end
            end
            2'd1, 2'd2: begin
                if (found && 32'(fill) >= 2*lz + 1) begin
                    // Field is 2^lz + info, so codeNum is simply the field minus one
                    code      = top >> (2*VALW - (2*lz + 1));
                    k         = VALW'(code - (2*VALW)'(1));
                    eval_done = 1'b1;
                    eval_cons = 2*lz + 1;
                    if (op_q == 2'd1)  eval_val = k;
                    else if (k[0])     eval_val = VALW'(({1'b0, k} + {{VALW{1'b0}}, 1'b1}) >> 1);
                    else               eval_val = '0 - (k >> 1);
                end else if (lz == VALW) begin
                    eval_done = 1'b1;
                    eval_err  = 1'b1;
                    eval_cons = VALW;
                end
            end
            default: begin
                eval_done = 1'b1;
                eval_err  = 1'b1;
            end
        endcase
    end

    // Consume from the head first, then append the new word right below what remains
    always_comb begin
        consume   = (state == S_WAIT && eval_done) ? eval_cons : 0;
        vl_eff    = (VL > 5'd20) ? 5'd20 : VL;
        accept    = VALID && READY;
        wl        = VE << (5'd20 - vl_eff);
        fill_c    = fill - FW'(consume);
        ins       = {wl, {(BUFW-20){1'b0}}} >> fill_c;
        buf_next  = (bitbuf << consume) | (accept ? ins : '0);
        fill_next = fill_c + (accept ? FW'(vl_eff) : '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bitbuf    <= '0;
            fill      <= '0;
            state     <= S_IDLE;
            op_q      <= '0;
            n_q       <= '0;
            RES_VALUE <= '0;
            RES_ERR   <= 1'b0;
        end else begin
            bitbuf <= buf_next;
            fill   <= fill_next;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        op_q  <= CMD_OP;
                        n_q   <= CMD_N;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eval_done) begin
                        RES_VALUE <= eval_val;
                        RES_ERR   <= eval_err;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef H264_BITREADER_BITCNT_EN
    always_ff @(posedge CLK) begin
        if (RST) BITPOS <= '0;
        else     BITPOS <= BITPOS + 32'(consume);
    end
`endif

endmodule
